jtag_tap_ctrl: RTL and testbench

//  Parametrised IEEE 1149.1-style TAP controller plus instruction register for wrapped cores.

---
 rtl/jtag_pkg.sv | 42 ++++
 rtl/jtag_tap_fsm.sv | 59 +++++
 rtl/jtag_tap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TAP controller slice:
//   - 4-bit TAP state codes (IEEE 1149.1 conventional encoding)
//   - DR selection kind enumeration
//   - small helper for shift-state detection
// No ports (package).
// -----------------------------------------------------------------------------
package jtag_pkg;

    // TAP state encoding; the codes match the conventional 1149.1 numbering
    // so tap_state can be compared directly against debugger traces.
    localparam logic [3:0] ST_TLR    = 4'hF;
    localparam logic [3:0] ST_RTI    = 4'hC;
    localparam logic [3:0] ST_SEL_DR = 4'h7;
    localparam logic [3:0] ST_CAP_DR = 4'h6;
    localparam logic [3:0] ST_SH_DR  = 4'h2;
    localparam logic [3:0] ST_EX1_DR = 4'h1;
    localparam logic [3:0] ST_PAU_DR = 4'h3;
    localparam logic [3:0] ST_EX2_DR = 4'h0;
    localparam logic [3:0] ST_UPD_DR = 4'h5;
    localparam logic [3:0] ST_SEL_IR = 4'h4;
    localparam logic [3:0] ST_CAP_IR = 4'hE;
    localparam logic [3:0] ST_SH_IR  = 4'hA;
    localparam logic [3:0] ST_EX1_IR = 4'h9;
    localparam logic [3:0] ST_PAU_IR = 4'hB;
    localparam logic [3:0] ST_EX2_IR = 4'h8;
    localparam logic [3:0] ST_UPD_IR = 4'hD;

    // Which data register sits between TDI and TDO for the current instruction.
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_kind_e;

    // True in the two states where TDO is driven.
    function automatic logic is_shift_state(input logic [3:0] st);
        return (st == ST_SH_DR) || (st == ST_SH_IR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// jtag_tap_fsm
// 16-state IEEE 1149.1 TAP state machine: state register and next-state logic.
// Ports:
//   clk_i    TCLK, rising-edge active
//   rst_i    synchronous active-high reset (forces TEST_LOGIC_RESET)
//   tms_i    test mode select, sampled on each rising edge
//   state_o  current state code (jtag_pkg encoding)
// -----------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tms_i,
    output logic [3:0] state_o
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    // Next-state table: every state has a TMS=0 and a TMS=1 successor.
    always_comb begin
        state_d = ST_TLR;
        case (state_q)
            ST_TLR:    state_d = tms_i ? ST_TLR    : ST_RTI;
            ST_RTI:    state_d = tms_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_d = tms_i ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_d = tms_i ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_d = tms_i ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_d = tms_i ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_d = tms_i ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_d = tms_i ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_d = tms_i ? ST_SEL_DR : ST_RTI;
            // SEL_IR with TMS=1 wraps back to reset, which is what makes
            // five TMS=1 edges sufficient from any state.
            ST_SEL_IR: state_d = tms_i ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_d = tms_i ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_d = tms_i ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_d = tms_i ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_d = tms_i ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_d = tms_i ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_d = tms_i ? ST_SEL_DR : ST_RTI;
            default:   state_d = ST_TLR;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_tap_ctrl
// TAP controller with parametrised instruction register, built-in BYPASS and
// IDCODE registers, and NUM_DR external user chains selected by opcode.
// Ports:
//   TCLK        clock (all state on rising edge)
//   TRST        synchronous active-high reset
//   TMS, TDI    test mode select / serial data in
//   TDO, TDO_EN serial data out (LSB of active shift reg) and its enable
//   ir_out      current (updated) instruction
//   dr_sel      one-hot user chain selection, 0 when no user chain selected
//   capture_dr, shift_dr, update_dr  user chain strobes (Moore)
//   ext_tdo     serial outputs of the user chains
//   tap_state   current FSM state code
//   tlr         high in TEST_LOGIC_RESET
// -----------------------------------------------------------------------------
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned         IR_WIDTH   = 4,
    parameter int unsigned         NUM_DR     = 2,
    parameter logic [31:0]         IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(32'h1),
    parameter logic [IR_WIDTH-1:0] OP_USER0   = IR_WIDTH'(32'h2)
) (
    input  logic                TCLK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [NUM_DR-1:0]   dr_sel,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    input  logic [NUM_DR-1:0]   ext_tdo,
    output logic [3:0]          tap_state,
    output logic                tlr
);

    logic [3:0]          state_s;

    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_d;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_shift_d;
    logic                bypass_q;
    logic                bypass_d;
    logic [31:0]         idcode_q;
    logic [31:0]         idcode_d;

    dr_kind_e            dr_kind_s;
    logic [NUM_DR-1:0]   dr_sel_s;
    logic                user_sel_s;
    logic                tdo_s;

    jtag_tap_fsm u_fsm (
        .clk_i   (TCLK),
        .rst_i   (TRST),
        .tms_i   (TMS),
        .state_o (state_s)
    );

    // Opcode decode. All-ones is always BYPASS and IDCODE beats a user
    // opcode that happens to alias it; unknown opcodes fall back to BYPASS.
    always_comb begin
        dr_sel_s = '0;
        if (ir_q == {IR_WIDTH{1'b1}}) begin
            dr_kind_s = DR_BYPASS;
        end else if (ir_q == OP_IDCODE) begin
            dr_kind_s = DR_IDCODE;
        end else begin
            for (int unsigned k = 0; k < NUM_DR; k++) begin
                dr_sel_s[k] = (ir_q == (OP_USER0 + IR_WIDTH'(k)));
            end
            dr_kind_s = (|dr_sel_s) ? DR_USER : DR_BYPASS;
        end
    end

    assign user_sel_s = (dr_kind_s == DR_USER);

    // Instruction register path: capture, shift and update.
    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        case (state_s)
            ST_TLR:    ir_d       = OP_IDCODE;
            // Fixed 2'b01 capture pattern lets a debugger find IR length.
            ST_CAP_IR: ir_shift_d = IR_WIDTH'(2'b01);
            ST_SH_IR:  ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
            ST_UPD_IR: ir_d       = ir_shift_q;
            default:   ir_d       = ir_q;
        endcase
    end

    // Built-in data registers; only the selected one captures or shifts.
    always_comb begin
        bypass_d = bypass_q;
        idcode_d = idcode_q;
        case (state_s)
            ST_CAP_DR: begin
                case (dr_kind_s)
                    DR_BYPASS: bypass_d = 1'b0;
                    DR_IDCODE: idcode_d = IDCODE_VAL | 32'h0000_0001;
                    default:   bypass_d = bypass_q;
                endcase
            end
            ST_SH_DR: begin
                case (dr_kind_s)
                    DR_BYPASS: bypass_d = TDI;
                    DR_IDCODE: idcode_d = {TDI, idcode_q[31:1]};
                    default:   bypass_d = bypass_q;
                endcase
            end
            default: bypass_d = bypass_q;
        endcase
    end

    // Register bank; TRST aborts any scan without touching ir beyond reset.
    always_ff @(posedge TCLK) begin
        if (TRST) begin
            ir_q       <= OP_IDCODE;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            idcode_q   <= 32'h0000_0000;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    // TDO mux: combinational from flops so the bit is valid before the
    // shifting edge and N edges read N bits LSB first.
    always_comb begin
        tdo_s = 1'b0;
        case (state_s)
            ST_SH_IR: tdo_s = ir_shift_q[0];
            ST_SH_DR: begin
                case (dr_kind_s)
                    DR_IDCODE: tdo_s = idcode_q[0];
                    DR_USER:   tdo_s = |(dr_sel_s & ext_tdo);
                    default:   tdo_s = bypass_q;
                endcase
            end
            default: tdo_s = 1'b0;
        endcase
    end

    assign TDO        = tdo_s;
    assign TDO_EN     = is_shift_state(state_s);
    assign ir_out     = ir_q;
    assign dr_sel     = dr_sel_s;
    assign capture_dr = (state_s == ST_CAP_DR) && user_sel_s;
    assign shift_dr   = (state_s == ST_SH_DR)  && user_sel_s;
    assign update_dr  = (state_s == ST_UPD_DR) && user_sel_s;
    assign tap_state  = state_s;
    assign tlr        = (state_s == ST_TLR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRST, TMS, TDI;
    logic       TDO, TDO_EN;
    logic [3:0] ir_out;
    logic [1:0] dr_sel;
    logic       capture_dr, shift_dr, update_dr;
    logic [1:0] ext_tdo;
    logic [3:0] tap_state;
    logic       tlr;

    jtag_tap_ctrl dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_EN(TDO_EN), .ir_out(ir_out), .dr_sel(dr_sel),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .ext_tdo(ext_tdo), .tap_state(tap_state), .tlr(tlr)
    );

    always #5 TCLK = ~TCLK;

    // Reference model. States are indices in the order the standard lists them:
    // 0 TLR 1 RTI 2 SEL_DR 3 CAP_DR 4 SH_DR 5 EX1_DR 6 PAU_DR 7 EX2_DR 8 UPD_DR
    // 9 SEL_IR 10 CAP_IR 11 SH_IR 12 EX1_IR 13 PAU_IR 14 EX2_IR 15 UPD_IR
    int         nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int         nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    logic [3:0] code [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

    int         m_st;
    logic [3:0] m_ir, m_irsh;
    logic       m_byp;
    logic [31:0] m_id;

    int   errors = 0;
    int   checks = 0;
    logic last_tdo;

    // 0 = bypass, 1 = idcode, 2+k = user chain k
    function automatic int m_kind(input logic [3:0] ir);
        if (ir == 4'hF) return 0;
        if (ir == 4'h1) return 1;
        if (ir == 4'h2) return 2;
        if (ir == 4'h3) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ir = 4'h1; m_irsh = 4'h0; m_byp = 1'b0; m_id = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCLK cycle: drive at negedge, check outputs, advance model, take edge.
    task automatic step(input logic tms, input logic tdi, input logic trst);
        int         kind;
        logic [1:0] sel;
        logic       etdo;
        logic       is_user, in_cap, in_sh, in_upd;
        @(negedge TCLK);
        TMS = tms; TDI = tdi; TRST = trst; ext_tdo = 2'($urandom);
        #1;
        kind    = m_kind(m_ir);
        is_user = (kind >= 2);
        sel     = is_user ? (2'b01 << (kind - 2)) : 2'b00;
        in_cap  = (m_st == 3); in_sh = (m_st == 4); in_upd = (m_st == 8);
        if (m_st == 11)      etdo = m_irsh[0];
        else if (m_st == 4)  etdo = (kind == 0) ? m_byp : (kind == 1) ? m_id[0] : ext_tdo[kind-2];
        else                 etdo = 1'b0;
        chk("tap_state", 32'(tap_state), 32'(code[m_st]));
        chk("tlr", 32'(tlr), 32'(m_st == 0));
        chk("tdo_en", 32'(TDO_EN), 32'(m_st == 4 || m_st == 11));
        chk("tdo", 32'(TDO), 32'(etdo));
        chk("ir_out", 32'(ir_out), 32'(m_ir));
        chk("dr_sel", 32'(dr_sel), 32'(sel));
        chk("capture_dr", 32'(capture_dr), 32'(in_cap && is_user));
        chk("shift_dr", 32'(shift_dr), 32'(in_sh && is_user));
        chk("update_dr", 32'(update_dr), 32'(in_upd && is_user));
        last_tdo = TDO;
        if (trst) begin
            model_reset();
        end else begin
            if (m_st == 0)  m_ir = 4'h1;
            if (m_st == 10) m_irsh = 4'h1;
            if (m_st == 11) m_irsh = {tdi, m_irsh[3:1]};
            if (m_st == 15) m_ir = m_irsh;
            if (m_st == 3 && kind == 0) m_byp = 1'b0;
            if (m_st == 3 && kind == 1) m_id = 32'h1234_5001 | 32'h1;
            if (m_st == 4 && kind == 0) m_byp = tdi;
            if (m_st == 4 && kind == 1) m_id = {tdi, m_id[31:1]};
            m_st = tms ? nxt1[m_st] : nxt0[m_st];
        end
        @(posedge TCLK);
    endtask

    // From RTI: load an instruction, return captured TDO bits, end in RTI.
    task automatic scan_ir(input logic [3:0] val, output logic [3:0] got);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, val[i], 1'b0);
            got[i] = last_tdo;
        end
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    endtask

    // From RTI: shift n bits through the selected DR, end in RTI.
    task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] got);
        got = 32'h0;
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], 1'b0);
            got[i] = last_tdo;
        end
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]  g4;
        logic [31:0] g32;
        logic [31:0] d32;
        int          n;

        TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; ext_tdo = 2'b00;
        repeat (2) @(posedge TCLK);
        model_reset();

        // reset values under TRST
        step(1'b0, 1'b0, 1'b1);
        #2;
        chk("rst_tlr", 32'(tlr), 32'd1);
        chk("rst_state", 32'(tap_state), 32'hF);
        chk("rst_ir", 32'(ir_out), 32'h1);

        // IDCODE readout after reset
        step(1'b0, 1'b0, 1'b0);
        scan_dr(32'($urandom), 32, g32);
        chk("idcode_stream", g32, 32'h1234_5001);

        // IR capture pattern and all-ones BYPASS
        scan_ir(4'hF, g4);
        chk("ir_capture", 32'(g4), 32'h1);
        #2;
        chk("ir_all_ones", 32'(ir_out), 32'hF);
        scan_dr(32'h0000_00A5, 9, g32);
        chk("bypass_a5", g32, 32'h0000_014A);

        // user chain 1, then unknown opcode 4'h7
        scan_ir(4'h3, g4);
        #2;
        chk("user1_sel", 32'(dr_sel), 32'h2);
        scan_dr(32'($urandom), 6, g32);
        scan_ir(4'h7, g4);
        #2;
        chk("op7_sel", 32'(dr_sel), 32'h0);
        d32 = 32'($urandom) & 32'h0000_00FF;
        scan_dr(d32, 9, g32);
        chk("op7_bypass", g32, d32 << 1);

        // TRST mid SH_IR after shifting 4'h2
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h2 >> i, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        #2;
        chk("trst_mid_state", 32'(tap_state), 32'hF);
        chk("trst_mid_ir", 32'(ir_out), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // five TMS=1 edges from every state
        for (int t = 0; t < 16; t++) begin
            n = 0;
            while (m_st != t && n < 400) begin
                step(1'($urandom), 1'($urandom), 1'b0);
                n++;
            end
            chk("reach_state", 32'(m_st == t), 32'd1);
            for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), 1'b0);
            #2;
            chk("tms5_tlr", 32'(tlr), 32'd1);
            chk("tms5_state", 32'(tap_state), 32'hF);
        end

        // free random traffic including occasional TRST
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
